// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl
//   First-word-fall-through FIFO controller in front of dual_port_bram.
//   RAM port A is the write port and port B the read port. A 2-entry output
//   buffer hides the RAM's one-cycle registered read latency, so both the
//   write side and the read side can move one word per cycle.
//
// Ports
//   i_CLK, i_RST_N            clock, asynchronous active-low reset
//   i_WR_VALID/i_WR_DATA      upstream word, accepted when o_WR_READY is high
//   o_WR_READY                RAM has a free slot
//   o_RD_VALID/o_RD_DATA      head word, consumed when i_RD_READY is high
//   i_RD_READY                downstream accepts the head word
//   o_COUNT                   words accepted and not yet delivered (0..DEPTH+2)
//   o_BRAM_*_A                RAM port A write strobe/address/data
//   o_BRAM_*_B, i_BRAM_*_B    RAM port B read strobe/address and returned data
//   o_ALMOST_FULL             registered (o_COUNT >= ALMOST_FULL_LEVEL); exists
//                             only when BRAM_FIFO_CTRL_ALMOST_FULL_EN is defined
module bram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
`ifdef BRAM_FIFO_CTRL_ALMOST_FULL_EN
  , parameter int ALMOST_FULL_LEVEL = 12
`endif
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_N,
  input  logic                  i_WR_VALID,
  input  logic [DATA_WIDTH-1:0] i_WR_DATA,
  output logic                  o_WR_READY,
  output logic                  o_RD_VALID,
  output logic [DATA_WIDTH-1:0] o_RD_DATA,
  input  logic                  i_RD_READY,
  output logic [ADDR_WIDTH+1:0] o_COUNT,
  output logic                  o_BRAM_WRITE_ENABLE_A,
  output logic [ADDR_WIDTH-1:0] o_BRAM_WRITE_ADDRESS_A,
  output logic [DATA_WIDTH-1:0] o_BRAM_WRITE_DATA_A,
  output logic                  o_BRAM_READ_ENABLE_B,
  output logic [ADDR_WIDTH-1:0] o_BRAM_READ_ADDRESS_B,
  input  logic [DATA_WIDTH-1:0] i_BRAM_READ_DATA_B
`ifdef BRAM_FIFO_CTRL_ALMOST_FULL_EN
  , output logic                o_ALMOST_FULL
`endif
);

  localparam int CW = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wp, rp;
  logic [ADDR_WIDTH:0]   ram_cnt, ram_cnt_n;
  logic                  inflight;
  logic [1:0]            ob_cnt, ob_cnt_n;
  logic                  ob_head;
  logic                  ob_tail;
  logic [DATA_WIDTH-1:0] ob_mem [2];

  logic       wr_fire, rd_fire, pop;
  logic [2:0] occ;

  // Ready depends on registered state only; gated so it reads 0 in reset.
  assign o_WR_READY = i_RST_N & (ram_cnt != DEPTH_C);
  assign wr_fire    = i_WR_VALID & o_WR_READY;

  assign o_RD_VALID = (ob_cnt != 2'd0);
  assign o_RD_DATA  = ob_mem[ob_head];
  assign pop        = o_RD_VALID & i_RD_READY;

  // Buffer occupancy after this cycle's pop, counting the word still in the RAM
  // pipeline; issue only while that leaves room for the word being requested.
  assign occ     = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign rd_fire = i_RST_N & (ram_cnt != '0) & (occ < 3'd2);

  // Tail slot is head when empty, the other slot when one word is held.
  assign ob_tail = ob_head ^ ob_cnt[0];

  assign o_BRAM_WRITE_ENABLE_A  = wr_fire;
  assign o_BRAM_WRITE_ADDRESS_A = wp;
  assign o_BRAM_WRITE_DATA_A    = i_WR_DATA;
  assign o_BRAM_READ_ENABLE_B   = rd_fire;
  assign o_BRAM_READ_ADDRESS_B  = rp;

  assign o_COUNT = CW'(ram_cnt) + CW'(inflight) + CW'(ob_cnt);

  always_comb begin
    ram_cnt_n = ram_cnt + (ADDR_WIDTH+1)'(wr_fire) - (ADDR_WIDTH+1)'(rd_fire);
    ob_cnt_n  = ob_cnt + 2'(inflight) - 2'(pop);
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      wp        <= '0;
      rp        <= '0;
      ram_cnt   <= '0;
      inflight  <= 1'b0;
      ob_cnt    <= '0;
      ob_head   <= 1'b0;
      ob_mem[0] <= '0;
      ob_mem[1] <= '0;
    end else begin
      wp       <= wp + ADDR_WIDTH'(wr_fire);
      rp       <= rp + ADDR_WIDTH'(rd_fire);
      ram_cnt  <= ram_cnt_n;
      inflight <= rd_fire;
      ob_cnt   <= ob_cnt_n;
      if (inflight) ob_mem[ob_tail] <= i_BRAM_READ_DATA_B;
      if (pop)      ob_head         <= ~ob_head;
    end
  end

`ifdef BRAM_FIFO_CTRL_ALMOST_FULL_EN
  logic [CW-1:0] count_n;
  assign count_n = CW'(ram_cnt_n) + CW'(rd_fire) + CW'(ob_cnt_n);

  // Registered from the next-state count so it matches o_COUNT after each edge.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) o_ALMOST_FULL <= 1'b0;
    else          o_ALMOST_FULL <= (count_n >= CW'(ALMOST_FULL_LEVEL));
  end
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
module tb_bram_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;
  logic [AW+1:0] count;
  logic          we_a;
  logic [AW-1:0] waddr_a;
  logic [DW-1:0] wdata_a;
  logic          re_b;
  logic [AW-1:0] raddr_b;
  logic [DW-1:0] rdata_b;

  logic [DW-1:0] ram [2**AW];

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned accepted = 0;
  int unsigned pops = 0;
  logic [DW-1:0] sb [$];

  bram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_CLK                  (clk),
    .i_RST_N                (rst_n),
    .i_WR_VALID             (wr_valid),
    .i_WR_DATA              (wr_data),
    .o_WR_READY             (wr_ready),
    .o_RD_VALID             (rd_valid),
    .o_RD_DATA              (rd_data),
    .i_RD_READY             (rd_ready),
    .o_COUNT                (count),
    .o_BRAM_WRITE_ENABLE_A  (we_a),
    .o_BRAM_WRITE_ADDRESS_A (waddr_a),
    .o_BRAM_WRITE_DATA_A    (wdata_a),
    .o_BRAM_READ_ENABLE_B   (re_b),
    .o_BRAM_READ_ADDRESS_B  (raddr_b),
    .i_BRAM_READ_DATA_B     (rdata_b)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM with registered read.
  always @(posedge clk) begin
    if (we_a) ram[waddr_a] <= wdata_a;
    if (re_b) rdata_b <= ram[raddr_b];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  // Called at the negedge: record an accepted write, then move past the edge.
  task automatic adv();
    if (wr_valid && wr_ready) begin
      sb.push_back(wr_data);
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      half();
      adv();
    end
  endtask

  // Scoreboard monitor: pops expected words whenever the DUT hands one over.
  logic          held = 1'b0;
  logic [DW-1:0] held_val;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held && rd_valid) chk("hold_stable", rd_data, held_val);
      if (rd_valid && rd_ready) begin
        pops++;
        if (sb.size() == 0) chk("unexpected_word", rd_data, 32'hDEAD);
        else chk("rd_data", rd_data, sb.pop_front());
        held = 1'b0;
      end else if (rd_valid) begin
        held     = 1'b1;
        held_val = rd_data;
      end
      if (count > 6'd18) chk("count_bound", count, 18);
      if (we_a && re_b) begin
        tests++;
        if (waddr_a == raddr_b) begin
          fails++;
          $display("FAIL collision: waddr %0h raddr %0h", waddr_a, raddr_b);
        end
      end
    end
  end

  initial begin
    int unsigned p0;
    int cyc;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    #3;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_en", {we_a, re_b}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    half();
    chk("post_rst_wr_ready", wr_ready, 1);
    chk("post_rst_rd_data", rd_data, 0);
    adv();

    // Mid-stream reset with five words held.
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h10 + 8'(i);
      half();
      adv();
    end
    wr_valid = 1'b0;
    idle(3);
    half();
    chk("pre_rst_count", count, 5);
    chk("pre_rst_valid", rd_valid, 1);
    adv();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rd_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_en", {we_a, re_b}, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    half();
    chk("rel_wr_ready", wr_ready, 1);
    adv();

    // Single word 0x46 with downstream ready.
    rd_ready = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h46;
    half();
    chk("sw_we", we_a, 1);
    chk("sw_waddr", waddr_a, 0);
    chk("sw_wdata", wdata_a, 8'h46);
    adv();
    wr_valid = 1'b0;
    half();
    chk("sw_c1_re", re_b, 1);
    chk("sw_c1_raddr", raddr_b, 0);
    chk("sw_c1_count", count, 1);
    adv();
    half();
    chk("sw_c2_valid", rd_valid, 0);
    chk("sw_c2_count", count, 1);
    adv();
    half();
    chk("sw_c3_valid", rd_valid, 1);
    chk("sw_c3_data", rd_data, 8'h46);
    chk("sw_c3_count", count, 1);
    adv();
    half();
    chk("sw_c4_count", count, 0);
    adv();

    // Fill with the output stalled: 18 of 20 offered words fit.
    rd_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      half();
      adv();
    end
    wr_valid = 1'b0;
    idle(2);
    half();
    chk("fill_accepted", accepted, 18);
    chk("fill_wr_ready", wr_ready, 0);
    chk("fill_count", count, 18);
    chk("fill_head", rd_data, 8'h00);
    adv();
    rd_ready = 1'b1;
    idle(25);
    chk("fill_drained", sb.size(), 0);
    chk("fill_empty_count", count, 0);

    // Full, then pop once while a write is offered.
    rd_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h60 + 8'(i);
      half();
      adv();
    end
    wr_valid = 1'b0;
    idle(2);
    wr_valid = 1'b1;
    wr_data  = 8'hA0;
    rd_ready = 1'b1;
    half();
    chk("full_wr_ready", wr_ready, 0);
    chk("full_we", we_a, 0);
    chk("full_re", re_b, 1);
    adv();
    rd_ready = 1'b0;
    half();
    chk("full_reopen", wr_ready, 1);
    chk("full_we2", we_a, 1);
    adv();
    wr_valid = 1'b0;
    half();
    chk("full_again", wr_ready, 0);
    adv();
    rd_ready = 1'b1;
    idle(25);
    chk("full_drained", sb.size(), 0);

    // Streaming 64 words, both sides ready.
    p0 = pops;
    for (int i = 0; i < 64; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      half();
      chk("stream_wr_ready", wr_ready, 1);
      adv();
    end
    wr_valid = 1'b0;
    chk("stream_pops_mid", pops - p0, 61);
    idle(3);
    chk("stream_pops_end", pops - p0, 64);
    chk("stream_drained", sb.size(), 0);

    // Backpressure with read-ready pattern 1,0,0,1.
    accepted = 0;
    cyc = 0;
    while (accepted < 24 && cyc < 200) begin
      wr_valid = 1'b1;
      wr_data  = 8'h80 + 8'(accepted);
      rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      half();
      adv();
      cyc++;
    end
    wr_valid = 1'b0;
    chk("bp_accepted", accepted, 24);
    rd_ready = 1'b1;
    idle(30);
    chk("bp_drained", sb.size(), 0);
    chk("bp_count", count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bram_fifo_ctrl.md
# bram_fifo_ctrl

Synchronous first-word-fall-through FIFO controller that sits directly upstream of `dual_port_bram`. It drives the RAM's port A as the write port and port B as the read port. It hides the RAM's one-cycle registered read latency behind a 2-entry output buffer, presenting valid/ready streams on both sides at one word per cycle.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: word width; must match the RAM.
- `ADDR_WIDTH`, default 4: RAM address width; RAM depth `DEPTH = 2**ADDR_WIDTH`.
- `ALMOST_FULL_LEVEL`, default 12: `o_COUNT` threshold for `o_ALMOST_FULL` (macro-enabled only).

Ports:
- `i_CLK`  in  1  clock; all state is updated on the rising edge.
- `i_RST_N`  in  1  asynchronous, active-low reset.
- `i_WR_VALID`  in  1  upstream word present.
- `i_WR_DATA`  in  DATA_WIDTH  upstream word.
- `o_WR_READY`  out  1  controller can accept a word.
- `o_RD_VALID`  out  1  head word present on `o_RD_DATA`.
- `o_RD_DATA`  out  DATA_WIDTH  head word.
- `i_RD_READY`  in  1  downstream accepts the head word.
- `o_COUNT`  out  ADDR_WIDTH+2  words accepted and not yet delivered (0..DEPTH+2).
- `o_BRAM_WRITE_ENABLE_A`, `o_BRAM_WRITE_ADDRESS_A`, `o_BRAM_WRITE_DATA_A`  out  1/ADDR_WIDTH/DATA_WIDTH  RAM port A write.
- `o_BRAM_READ_ENABLE_B`, `o_BRAM_READ_ADDRESS_B`  out  1/ADDR_WIDTH  RAM port B read request.
- `i_BRAM_READ_DATA_B`  in  DATA_WIDTH  RAM port B registered read data.
- `o_ALMOST_FULL`  out  1  present only with the macro.

## Operation
- **State:** write pointer `wp` and read pointer `rp`, each ADDR_WIDTH bits and wrapping modulo DEPTH. Also `ram_cnt` (0..DEPTH), `inflight` (1 bit), and a 2-entry output buffer with `ob_cnt` (0..2).
- **Write:** `o_WR_READY = (ram_cnt < DEPTH)`, registered-state only and independent of same-cycle reads. On `i_WR_VALID & o_WR_READY`: `o_BRAM_WRITE_ENABLE_A = 1`, address `wp`, data `i_WR_DATA`; `wp++`; `ram_cnt++`.
- **Read issue:** `o_BRAM_READ_ENABLE_B = (ram_cnt != 0) & (ob_cnt + inflight - pop < 2)`, where `pop = o_RD_VALID & i_RD_READY`. Address is `rp`. On issue: `rp++`, `ram_cnt--`, `inflight <= 1`; otherwise `inflight <= 0`.
- **Capture:** when `inflight = 1`, `i_BRAM_READ_DATA_B` is written into the output buffer tail in that cycle.
- **Output:** `o_RD_VALID = (ob_cnt != 0)`; `o_RD_DATA` = buffer head. On pop, the head advances. Head data holds stable while `o_RD_VALID & !i_RD_READY`.
- **Count:** `o_COUNT = ram_cnt + inflight + ob_cnt`. Write and issue in the same cycle leave `ram_cnt` unchanged. Capture and pop in the same cycle leave `ob_cnt` unchanged.
- **No collisions:** a read is never issued to the address written in the same cycle. With `ram_cnt = 0` no read is issued, and with `ram_cnt = DEPTH` no write is accepted.
- **Order:** strict FIFO order; no word is dropped or duplicated under any valid/ready pattern.
- **Reset (asynchronous assert, any time including mid-transfer):**
  - `wp`, `rp`, `ram_cnt`, `inflight` and `ob_cnt` all go to 0; `o_RD_DATA` goes to 0.
  - Any in-flight read is discarded.
  - RAM contents are untouched but logically empty.
  - While `i_RST_N = 0`: `o_WR_READY`, `o_RD_VALID`, all BRAM enables and `o_COUNT` are 0.

## Timing
- **Accept-to-valid latency:** 3 cycles on an idle FIFO. A word accepted at edge 0 is read-issued in cycle 1, arrives on `i_BRAM_READ_DATA_B` in cycle 2, is captured at edge 2, and `o_RD_VALID` is high in cycle 3.
- **Throughput:** sustained 1 word/cycle with both sides always ready.
- **Capacity:** DEPTH+2 words (RAM plus output buffer). `o_WR_READY` falls the cycle after `ram_cnt` reaches DEPTH and rises the cycle after the first read issue that frees a slot.
- **Backpressure:** `i_RD_READY` low for N cycles stalls issue once `ob_cnt + inflight = 2`. No data is lost, and the buffer never exceeds 2 entries.
- **Post-reset:** `o_WR_READY = 1` in the first cycle after `i_RST_N` deasserts.

## Configuration
- **Macro `BRAM_FIFO_CTRL_ALMOST_FULL_EN`:**
  - Defined: port `o_ALMOST_FULL` exists, is registered, and equals `(o_COUNT >= ALMOST_FULL_LEVEL)` as of the previous edge; it resets to 0.
  - Undefined: the port, its register and `ALMOST_FULL_LEVEL` checking are absent; all other behaviour is identical.

## Test plan
- **Reset:** assert `i_RST_N = 0` mid-stream with `o_COUNT = 5` -> same cycle, `o_RD_VALID = 0`, `o_COUNT = 0`, BRAM enables 0. After release, `o_WR_READY = 1` and the next word written (0x46) is the first word read.
- **Single word:** write 0x46 at cycle 0 with `i_RD_READY = 1` -> read enable at cycle 1, address 0; `o_RD_VALID = 1`, `o_RD_DATA = 0x46` at cycle 3; `o_COUNT` goes 1, 1, 1, 0.
- **Fill:** `i_RD_READY = 0`, write 0x00..0x13 -> exactly 18 words accepted; `o_WR_READY = 0` afterwards; `o_COUNT = 18`; `o_RD_DATA = 0x00`. With the macro and `ALMOST_FULL_LEVEL` 12, `o_ALMOST_FULL` rises the cycle after the 12th accept.
- **Streaming wrap:** 64 words 0x00..0x3F with both sides ready -> outputs in order, one per cycle after 3-cycle latency; `wp`/`rp` wrap 4 times; `o_WR_READY` never drops.
- **Backpressure:** stream with `i_RD_READY` toggling 1,0,0,1 -> `o_RD_DATA` stable while stalled; sequence intact; `o_COUNT` never exceeds DEPTH+2.
- **Full plus simultaneous:** with the FIFO full, pop one word while `i_WR_VALID = 1` -> write is accepted only after `o_WR_READY` re-asserts; no write/read address collision on the RAM ports.
